// File: rtl/alu_rr_scheduler.sv
// Round-robin grant scheduler for the shared 16-bit ALU datapath.
// One registered one-hot tenure at a time, with a one-cycle turnaround gap between tenures.
module alu_rr_scheduler #(
  parameter int N       = 16,
  parameter int IDW     = 4,
  parameter int MAXHOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   g,
  output logic [IDW-1:0] gid,
  output logic           gvalid,
  output logic           timeout,
  output logic [IDW-1:0] ptr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     hold;

  logic [N-1:0]   mask;
  logic [N-1:0]   masked;
  logic [N-1:0]   pick_oh;
  logic [IDW-1:0] lo_masked;
  logic [IDW-1:0] lo_req;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] next_ptr;

  logic           holder_req;
  logic           at_limit;
  logic           tenure_end;
  logic           preempt;

  // Rotating priority: requesters at or above ptr win before the wrapped-around ones.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi]    = (IDW'(gi) >= ptr);
      assign masked[gi]  = req[gi] & mask[gi];
      assign pick_oh[gi] = (pick_idx == IDW'(gi));
    end
  endgenerate

  always_comb begin
    lo_masked = '0;
    lo_req    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) lo_masked = IDW'(i);
      if (req[i])    lo_req    = IDW'(i);
    end
    pick_idx = (|masked) ? lo_masked : lo_req;
  end

  assign holder_req = req[gid];
  assign at_limit   = (hold == 4'(MAXHOLD - 1));
  assign tenure_end = done | ~holder_req | at_limit;
  // A limit hit only counts as preemption when neither done nor withdrawal ended it first.
  assign preempt    = ~done & holder_req & at_limit;
  assign next_ptr   = (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      g       <= '0;
      gid     <= '0;
      gvalid  <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      hold    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (|req) begin
            state  <= GRANT;
            g      <= pick_oh;
            gid    <= pick_idx;
            gvalid <= 1'b1;
            hold   <= '0;
          end else begin
            state  <= IDLE;
            g      <= '0;
            gvalid <= 1'b0;
          end
        end
        GRANT: begin
          hold <= (hold == 4'hF) ? hold : hold + 4'd1;
          if (tenure_end) begin
            state   <= GAP;
            g       <= '0;
            gvalid  <= 1'b0;
            ptr     <= next_ptr;
            timeout <= preempt;
          end
        end
        default: begin
          state  <= IDLE;
          g      <= '0;
          gvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: cycle scoreboard against a rotating-search model plus directed checks.
module tb_alu_rr_scheduler;

  localparam int MAXHOLD = 8;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic        done;
  logic [15:0] g;
  logic [3:0]  gid;
  logic        gvalid;
  logic        timeout;
  logic [3:0]  ptr;

  alu_rr_scheduler #(.N(16), .IDW(4), .MAXHOLD(MAXHOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .g       (g),
    .gid     (gid),
    .gvalid  (gvalid),
    .timeout (timeout),
    .ptr     (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] g;
    logic [3:0]  gid;
    logic        gvalid;
    logic        timeout;
    logic [3:0]  ptr;
  } exp_t;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  // Reference model: 0 idle, 1 grant, 2 gap; m_len counts granted cycles in the tenure.
  int          m_state;
  logic [15:0] m_g;
  logic [3:0]  m_gid;
  logic        m_gvalid;
  logic        m_timeout;
  logic [3:0]  m_ptr;
  int          m_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [15:0] r, input logic [3:0] p);
    int idx;
    for (int k = 0; k < 16; k++) begin
      idx = (int'(p) + k) % 16;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic [15:0] r, input logic d);
    int w;
    if (rst) begin
      m_state = 0; m_g = '0; m_gid = '0; m_gvalid = 1'b0;
      m_timeout = 1'b0; m_ptr = '0; m_len = 0;
    end else begin
      m_timeout = 1'b0;
      if (m_state == 1) begin
        if (d || !r[m_gid] || m_len == MAXHOLD) begin
          m_timeout = !d && r[m_gid];
          m_ptr     = 4'((int'(m_gid) + 1) % 16);
          m_g       = '0;
          m_gvalid  = 1'b0;
          m_state   = 2;
        end else begin
          m_len++;
        end
      end else begin
        w = rr_pick(r, m_ptr);
        if (w >= 0) begin
          m_state  = 1;
          m_gid    = 4'(w);
          m_g      = 16'd1 << w;
          m_gvalid = 1'b1;
          m_len    = 1;
        end else begin
          m_state  = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, push the model's expectation, compare after the edge.
  task automatic step(input logic rst, input logic [15:0] r, input logic d);
    exp_t e;
    reset = rst;
    req   = r;
    done  = d;
    model_step(rst, r, d);
    e.g = m_g; e.gid = m_gid; e.gvalid = m_gvalid; e.timeout = m_timeout; e.ptr = m_ptr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_g",       32'(g),       32'(e.g));
    check("sb_gvalid",  32'(gvalid),  32'(e.gvalid));
    check("sb_timeout", 32'(timeout), 32'(e.timeout));
    check("sb_ptr",     32'(ptr),     32'(e.ptr));
    if (e.gvalid) check("sb_gid", 32'(gid), 32'(e.gid));
    if (e.gvalid && m_len == 1)
      $display("[TB] grant gid=%0d ptr=%0d req=%04h t=%0t", e.gid, e.ptr, r, $time);
  endtask

  task automatic do_reset();
    step(1'b1, 16'h0000, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
  endtask

  logic [15:0] rreq;
  logic        rdone;
  logic        rrst;

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b1; req = '0; done = 1'b0;
    m_state = 0; m_g = '0; m_gid = '0; m_gvalid = 1'b0;
    m_timeout = 1'b0; m_ptr = '0; m_len = 0;

    // Reset with all requests and done active
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 16'hFFFF, 1'b1);
      check("rst_g",       32'(g),       32'h0);
      check("rst_gid",     32'(gid),     32'h0);
      check("rst_gvalid",  32'(gvalid),  32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      check("rst_ptr",     32'(ptr),     32'h0);
    end
    step(1'b0, 16'hFFFF, 1'b0);
    check("rst_first_grant", 32'(g), 32'h0001);

    // Single requester with done on the third grant cycle
    do_reset();
    step(1'b0, 16'h0010, 1'b0);
    check("single_g",   32'(g),   32'h0010);
    check("single_gid", 32'(gid), 32'd4);
    step(1'b0, 16'h0010, 1'b0);
    step(1'b0, 16'h0010, 1'b0);
    check("single_hold3", 32'(gvalid), 32'd1);
    step(1'b0, 16'h0010, 1'b1);
    check("single_gap_g", 32'(g),   32'h0);
    check("single_ptr",   32'(ptr), 32'd5);
    step(1'b0, 16'h0010, 1'b0);
    check("single_regrant", 32'(gid), 32'd4);

    // Fair rotation and wrap with done every grant cycle
    do_reset();
    for (int k = 0; k < 18; k++) begin
      step(1'b0, 16'hFFFF, 1'b0);
      check("rot_gid", 32'(gid), 32'(k % 16));
      step(1'b0, 16'hFFFF, 1'b1);
      check("rot_gap", 32'(gvalid), 32'd0);
      if (k == 15) check("rot_ptr_wrap", 32'(ptr), 32'd0);
    end

    // Skip and wrap: ptr reaches 2 via grants 0 and 1
    do_reset();
    step(1'b0, 16'h0003, 1'b0);
    step(1'b0, 16'h0003, 1'b1);
    step(1'b0, 16'h0003, 1'b0);
    check("skip_pre_gid", 32'(gid), 32'd1);
    step(1'b0, 16'h0003, 1'b1);
    check("skip_ptr2", 32'(ptr), 32'd2);
    step(1'b0, 16'h8003, 1'b0);
    check("skip_gid15", 32'(gid), 32'd15);
    step(1'b0, 16'h8003, 1'b1);
    step(1'b0, 16'h8003, 1'b0);
    check("skip_gid0", 32'(gid), 32'd0);
    step(1'b0, 16'h8003, 1'b1);
    step(1'b0, 16'h8003, 1'b0);
    check("skip_gid1", 32'(gid), 32'd1);

    // Preemption by hold limit, then done coinciding with the limit cycle
    do_reset();
    for (int c = 0; c < MAXHOLD; c++) step(1'b0, 16'h0006, 1'b0);
    check("pre_last_gvalid", 32'(gvalid), 32'd1);
    check("pre_last_gid",    32'(gid),    32'd1);
    step(1'b0, 16'h0006, 1'b0);
    check("pre_gap_g",   32'(g),       32'h0);
    check("pre_timeout", 32'(timeout), 32'd1);
    step(1'b0, 16'h0006, 1'b0);
    check("pre_next_gid", 32'(gid),     32'd2);
    check("pre_to_clear", 32'(timeout), 32'd0);
    for (int c = 1; c < MAXHOLD; c++) step(1'b0, 16'h0006, 1'b0);
    step(1'b0, 16'h0006, 1'b1);
    check("done_limit_timeout", 32'(timeout), 32'd0);
    check("done_limit_ptr",     32'(ptr),     32'd3);

    // Withdrawal by the holder
    do_reset();
    step(1'b0, 16'h0008, 1'b0);
    step(1'b0, 16'h0008, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("wd_g",   32'(g),   32'h0);
    check("wd_ptr", 32'(ptr), 32'd4);

    // Reset in the middle of a tenure
    do_reset();
    step(1'b0, 16'h0021, 1'b0);
    step(1'b0, 16'h0021, 1'b1);
    step(1'b0, 16'h0021, 1'b0);
    check("mr_gid5", 32'(gid), 32'd5);
    step(1'b0, 16'h0021, 1'b0);
    step(1'b1, 16'h0021, 1'b1);
    check("mr_g",      32'(g),      32'h0);
    check("mr_gid",    32'(gid),    32'h0);
    check("mr_gvalid", 32'(gvalid), 32'h0);
    check("mr_ptr",    32'(ptr),    32'h0);
    step(1'b0, 16'h0021, 1'b0);
    check("mr_first_gid", 32'(gid), 32'd0);

    // Random traffic against the model
    do_reset();
    rreq = 16'h0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rreq[$urandom_range(0, 15)] ^= 1'b1;
      rdone = ($urandom_range(0, 5) == 0);
      rrst  = ($urandom_range(0, 99) == 0);
      step(rrst, rreq, rdone);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
